// File: rtl/display_pkg.sv
// Shared types and default timing constants for the two-digit display scheduler.
package display_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_RECORD = 2'd1,
        MODE_PLAY   = 2'd2,
        MODE_PAUSE  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_REC   = 2'd1,
        SRC_PLAY  = 2'd2,
        SRC_SPEED = 2'd3
    } src_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_TIME    = 2'd1,
        S_OVERLAY = 2'd2
    } state_e;

    localparam int unsigned DEF_HOLD_CYCLES = 50_000_000;
    localparam int unsigned DEF_BLINK_HALF  = 12_500_000;

    // Counter width able to hold n-1; never narrower than one bit.
    function automatic int unsigned timer_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable saturating down-counter with a terminal (zero) flag.
module cycle_timer #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Priority: clear, then load, then decrement; stops at zero.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/display_scheduler.sv
// Chooses what the shared seven-segment pair shows: recorder/player time,
// a timed speed overlay, or blank; blinks the player time while paused.
module display_scheduler
    import display_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int unsigned BLINK_HALF  = DEF_BLINK_HALF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_mode,
    input  logic [4:0] i_rec_sec,
    input  logic [4:0] i_play_sec,
    input  logic       i_speed_req,
    input  logic [4:0] i_speed,
    output logic [4:0] o_hex,
    output logic       o_blank,
    output logic [1:0] o_src
);

    localparam int unsigned HOLD_W  = timer_width(HOLD_CYCLES);
    localparam int unsigned BLINK_W = timer_width(BLINK_HALF);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_HALF - 1);

    mode_e       mode;
    state_e      state_q,  state_d;
    logic [4:0]  speed_q,  speed_d;
    logic        phase_q,  phase_d;
    logic        act_q,    act_d;
    logic [4:0]  hex_q,    hex_d;
    logic        blank_q,  blank_d;
    src_e        src_q,    src_d;

    logic        hold_zero;
    logic        blink_zero;
    logic        blink_run;
    logic        blink_load;

    assign mode = mode_e'(i_mode);

    // Blinking runs only while paused in S_TIME; a speed request pre-empts it.
    assign blink_run  = (state_q == S_TIME) && (mode == MODE_PAUSE) && !i_speed_req;
    assign blink_load = blink_run && (!act_q || blink_zero);

    cycle_timer #(.WIDTH(HOLD_W)) u_hold (
        .clk_i      (i_clk),
        .rst_i      (i_rst),
        .clear_i    (1'b0),
        .load_i     (i_speed_req),
        .load_val_i (HOLD_LOAD),
        .en_i       (state_q == S_OVERLAY),
        .zero_o     (hold_zero)
    );

    cycle_timer #(.WIDTH(BLINK_W)) u_blink (
        .clk_i      (i_clk),
        .rst_i      (i_rst),
        .clear_i    (!blink_run),
        .load_i     (blink_load),
        .load_val_i (BLINK_LOAD),
        .en_i       (blink_run),
        .zero_o     (blink_zero)
    );

    always_comb begin
        state_d = state_q;
        speed_d = speed_q;
        act_d   = blink_run;
        phase_d = 1'b0;

        // First paused cycle only arms the timer; later expiries flip the phase.
        if (blink_run && act_q) begin
            phase_d = blink_zero ? ~phase_q : phase_q;
        end

        if (i_speed_req) begin
            state_d = S_OVERLAY;
            speed_d = i_speed;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mode != MODE_IDLE) state_d = S_TIME;
                end
                S_TIME: begin
                    if (mode == MODE_IDLE) state_d = S_IDLE;
                end
                S_OVERLAY: begin
                    if (hold_zero) state_d = (mode != MODE_IDLE) ? S_TIME : S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        hex_d   = '0;
        blank_d = 1'b1;
        src_d   = SRC_NONE;
        case (state_q)
            S_TIME: begin
                case (mode)
                    MODE_RECORD: begin
                        hex_d   = i_rec_sec;
                        src_d   = SRC_REC;
                        blank_d = 1'b0;
                    end
                    MODE_PLAY: begin
                        hex_d   = i_play_sec;
                        src_d   = SRC_PLAY;
                        blank_d = 1'b0;
                    end
                    MODE_PAUSE: begin
                        hex_d   = i_play_sec;
                        src_d   = SRC_PLAY;
                        blank_d = phase_d;
                    end
                    default: ;
                endcase
            end
            S_OVERLAY: begin
                hex_d   = speed_q;
                src_d   = SRC_SPEED;
                blank_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            speed_q <= '0;
            phase_q <= 1'b0;
            act_q   <= 1'b0;
            hex_q   <= '0;
            blank_q <= 1'b1;
            src_q   <= SRC_NONE;
        end else begin
            state_q <= state_d;
            speed_q <= speed_d;
            phase_q <= phase_d;
            act_q   <= act_d;
            hex_q   <= hex_d;
            blank_q <= blank_d;
            src_q   <= src_d;
        end
    end

    assign o_hex   = hex_q;
    assign o_blank = blank_q;
    assign o_src   = src_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with short hold/blink periods.
module tb_display_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic [4:0] rec_sec;
    logic [4:0] play_sec;
    logic       speed_req;
    logic [4:0] speed;
    logic [4:0] hex;
    logic       blank;
    logic [1:0] src;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    display_scheduler #(
        .HOLD_CYCLES (8),
        .BLINK_HALF  (4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_mode      (mode),
        .i_rec_sec   (rec_sec),
        .i_play_sec  (play_sec),
        .i_speed_req (speed_req),
        .i_speed     (speed),
        .o_hex       (hex),
        .o_blank     (blank),
        .o_src       (src)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [4:0] e_hex,
                             input logic e_blank, input logic [1:0] e_src);
        check({tag, ".hex"},   32'(hex),   32'(e_hex));
        check({tag, ".blank"}, 32'(blank), 32'(e_blank));
        check({tag, ".src"},   32'(src),   32'(e_src));
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; mode = 2'd0; rec_sec = '0; play_sec = '0;
        speed_req = 1'b0; speed = '0;
        tick(); tick();
        check_out("reset", 5'd0, 1'b1, 2'd0);
        rst = 1'b0;

        // Record mode shows up two edges after the mode change.
        mode = 2'd1; rec_sec = 5'd5;
        tick();
        check_out("rec_lat1", 5'd0, 1'b1, 2'd0);
        tick();
        check_out("rec", 5'd5, 1'b0, 2'd1);
        rec_sec = 5'd9;
        tick();
        check_out("rec_track", 5'd9, 1'b0, 2'd1);

        mode = 2'd2; play_sec = 5'd17;
        tick();
        check_out("play", 5'd17, 1'b0, 2'd2);

        // Single speed overlay: exactly eight cycles.
        speed_req = 1'b1; speed = 5'd2;
        tick();
        speed_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_out("ovl1", 5'd2, 1'b0, 2'd3);
        end
        tick();
        check_out("ovl1_end", 5'd17, 1'b0, 2'd2);

        // Retrigger during the fifth overlay cycle.
        speed_req = 1'b1; speed = 5'd3;
        tick();
        speed_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out("ovl2a", 5'd3, 1'b0, 2'd3);
        end
        speed_req = 1'b1; speed = 5'd4;
        tick();
        speed_req = 1'b0;
        check_out("ovl2_retrig", 5'd3, 1'b0, 2'd3);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_out("ovl2b", 5'd4, 1'b0, 2'd3);
        end
        tick();
        check_out("ovl2_end", 5'd17, 1'b0, 2'd2);

        // Pause blinking, interrupted while blanked.
        mode = 2'd3;
        for (int i = 0; i < 14; i++) begin
            tick();
            check_out("blink1", 5'd17, logic'((i / 4) % 2), 2'd2);
        end
        speed_req = 1'b1; speed = 5'd6;
        tick();
        speed_req = 1'b0;
        check("blink_cut", 32'(blank), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_out("ovl3", 5'd6, 1'b0, 2'd3);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            check_out("blink2", 5'd17, logic'((i / 4) % 2), 2'd2);
        end

        // Reset in the middle of an overlay, with a colliding speed request.
        mode = 2'd2;
        tick();
        check_out("unpause", 5'd17, 1'b0, 2'd2);
        speed_req = 1'b1; speed = 5'd9;
        tick();
        speed_req = 1'b0;
        tick(); tick();
        check_out("ovl4", 5'd9, 1'b0, 2'd3);
        rst = 1'b1; speed_req = 1'b1; speed = 5'd12;
        tick();
        rst = 1'b0; speed_req = 1'b0;
        check_out("mid_rst", 5'd0, 1'b1, 2'd0);
        tick();
        check_out("post_rst", 5'd0, 1'b1, 2'd0);
        tick();
        check_out("post_rst_play", 5'd17, 1'b0, 2'd2);

        // Mode drops to IDLE together with a speed request.
        mode = 2'd0; speed_req = 1'b1; speed = 5'd7;
        tick();
        speed_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_out("ovl5", 5'd7, 1'b0, 2'd3);
        end
        tick();
        check_out("ovl5_idle", 5'd0, 1'b1, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
